// File: rtl/button_sync_filter.sv
// Pushbutton front end: synchroniser chain, then a stability filter (FSM plus counter)
// giving a clean active-low level, press/release strobes and a busy flag.
// Optional rejected-bounce counter, enabled by defining GLITCH_COUNT_EN.
module button_sync_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_WIDTH     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_n_raw,
  input  logic       glitch_clr,
  output logic       btn_n_out,
  output logic       fall_evt,
  output logic       rise_evt,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    STAB_HI = 2'b00,
    CHK_LO  = 2'b01,
    STAB_LO = 2'b10,
    CHK_HI  = 2'b11
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;

  state_t               state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic                 out_next;
  logic                 fall_next;
  logic                 rise_next;
  logic                 busy_next;
  logic                 glitch_abort;

  // Flops reset to the idle (released) level so reset never looks like a press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_n_raw};
    end
  end

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= STAB_HI;
      cnt       <= '0;
      btn_n_out <= 1'b1;
      fall_evt  <= 1'b0;
      rise_evt  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      btn_n_out <= out_next;
      fall_evt  <= fall_next;
      rise_evt  <= rise_next;
      busy      <= busy_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    out_next     = btn_n_out;
    fall_next    = 1'b0;
    rise_next    = 1'b0;
    glitch_abort = 1'b0;

    case (state)
      STAB_HI: begin
        if (!btn_s) begin
          state_next = CHK_LO;
          cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (btn_s) begin
          state_next   = STAB_HI;
          glitch_abort = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = STAB_LO;
          out_next   = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      STAB_LO: begin
        if (btn_s) begin
          state_next = CHK_HI;
          cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!btn_s) begin
          state_next   = STAB_LO;
          glitch_abort = 1'b1;
        end else if (cnt == CNT_LAST) begin
          state_next = STAB_HI;
          out_next   = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_next = STAB_HI;
        out_next   = 1'b1;
      end
    endcase

    // busy is registered from the next state so it lines up with the CHECK cycles.
    busy_next = (state_next == CHK_LO) || (state_next == CHK_HI);
  end

`ifdef GLITCH_COUNT_EN
  logic [7:0] glitch_q;

  // Clear wins over a same-cycle abort; the count sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glitch_q <= 8'd0;
    end else if (glitch_clr) begin
      glitch_q <= 8'd0;
    end else if (glitch_abort && (glitch_q != 8'hFF)) begin
      glitch_q <= glitch_q + 8'd1;
    end
  end

  assign glitch_cnt = glitch_q;
`else
  logic unused_glitch;

  assign unused_glitch = glitch_clr ^ glitch_abort;
  assign glitch_cnt    = 8'd0;
`endif

endmodule
